udp_rx_parser: RTL and testbench

- Sits directly downstream of the IP receive stage in the FPGA2 receive header-clipper chain.
- Consumes the 16-bit UDP segment stream (udpvalidin/udpsof/udpeof/udpdatain), parses and strips the 4-word UDP header, filters on destination port and checks the length field.
- Forwards the payload words with their own sof/eof framing to the application receive logic.

---
 rtl/udp_rx_parser_pkg.sv | 25 ++
 rtl/udp_rx_parser_if.sv | 21 ++
 rtl/udp_rx_parser.sv | 138 +++++++++++++
 tb/tb_udp_rx_parser.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_parser_pkg.sv
// Shared definitions for the UDP receive parser: FSM encoding, header word
// indices and the expected-payload-word arithmetic.
package udp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_DROP = 2'd3
  } udp_state_e;

  localparam logic [1:0] HW_SRC  = 2'd0;
  localparam logic [1:0] HW_DST  = 2'd1;
  localparam logic [1:0] HW_LEN  = 2'd2;
  localparam logic [1:0] HW_CSUM = 2'd3;

  localparam int UDP_HDR_BYTES = 8;

  // Payload words implied by a length field, rounding an odd trailing byte up.
  function automatic logic [15:0] exp_words(input logic [15:0] len);
    if (len < 16'(UDP_HDR_BYTES)) return 16'd0;
    return (len - 16'(UDP_HDR_BYTES) + 16'd1) >> 1;
  endfunction

endpackage

// File: rtl/udp_rx_parser_if.sv
// Segment input stream and payload output stream of the UDP receive parser.
interface udp_rx_parser_if;
  logic        udpvalidin;
  logic        udpsof;
  logic        udpeof;
  logic [15:0] udpdatain;
  logic        payvalid;
  logic        paysof;
  logic        payeof;
  logic [15:0] paydata;

  modport master (
    output udpvalidin, udpsof, udpeof, udpdatain,
    input  payvalid, paysof, payeof, paydata
  );

  modport slave (
    input  udpvalidin, udpsof, udpeof, udpdatain,
    output payvalid, paysof, payeof, paydata
  );
endinterface

// File: rtl/udp_rx_parser.sv
// Strips the 4-word UDP header, filters on destination port, checks the length
// field against the payload word count and forwards payload with its own framing.
module udp_rx_parser
  import udp_pkg::*;
#(
  parameter bit          PORT_FILTER = 1'b1,
  parameter logic [15:0] MIN_LEN     = 16'd8
) (
  input  logic            clock,
  input  logic            reset,
  udp_rx_parser_if.slave  udp,
  input  logic [15:0]     localport,
  output logic [15:0]     srcport,
  output logic [15:0]     udplen,
  output logic            hdrvalid,
  output logic            drop,
  output logic            lenerr,
  output logic            abort
);

  udp_state_e  state_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] src_q, len_q, exp_q;
  logic [15:0] exp_w;
  logic        payvalid_q, paysof_q, payeof_q;
  logic [15:0] paydata_q, srcport_q, udplen_q;
  logic        hdrvalid_q, drop_q, lenerr_q, abort_q;

  assign exp_w = exp_words(len_q);
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      src_q      <= '0;
      len_q      <= '0;
      exp_q      <= '0;
      payvalid_q <= 1'b0;
      paysof_q   <= 1'b0;
      payeof_q   <= 1'b0;
      paydata_q  <= '0;
      srcport_q  <= '0;
      udplen_q   <= '0;
      hdrvalid_q <= 1'b0;
      drop_q     <= 1'b0;
      lenerr_q   <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      payvalid_q <= 1'b0;
      paysof_q   <= 1'b0;
      payeof_q   <= 1'b0;
      paydata_q  <= '0;
      hdrvalid_q <= 1'b0;
      drop_q     <= 1'b0;
      lenerr_q   <= 1'b0;
      abort_q    <= 1'b0;
      if (udp.udpvalidin) begin
        // A new sof always wins: restart on this word as header word 0.
        if (udp.udpsof) begin
          abort_q <= (state_q == ST_PAY);
          src_q   <= udp.udpdatain;
          if (udp.udpeof) begin
            drop_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_HDR;
            cnt_q   <= 16'(HW_DST);
          end
        end else begin
          case (state_q)
            ST_HDR: begin
              if (udp.udpeof && cnt_q[1:0] != HW_CSUM) begin
                drop_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                case (cnt_q[1:0])
                  HW_DST: begin
                    if (PORT_FILTER && udp.udpdatain != localport) state_q <= ST_DROP;
                    cnt_q <= 16'(HW_LEN);
                  end
                  HW_LEN: begin
                    len_q <= udp.udpdatain;
                    if (udp.udpdatain < MIN_LEN) state_q <= ST_DROP;
                    cnt_q <= 16'(HW_CSUM);
                  end
                  default: begin
                    hdrvalid_q <= 1'b1;
                    srcport_q  <= src_q;
                    udplen_q   <= len_q;
                    exp_q      <= exp_w;
                    cnt_q      <= '0;
                    if (udp.udpeof) begin
                      lenerr_q <= (exp_w != 16'd0);
                      state_q  <= ST_IDLE;
                    end else begin
                      state_q  <= (exp_w == 16'd0) ? ST_IDLE : ST_PAY;
                    end
                  end
                endcase
              end
            end
            ST_PAY: begin
              payvalid_q <= 1'b1;
              paydata_q  <= udp.udpdatain;
              paysof_q   <= (cnt_q == 16'd0);
              cnt_q      <= cnt_d;
              if (udp.udpeof) begin
                payeof_q <= 1'b1;
                lenerr_q <= (cnt_d != exp_q);
                state_q  <= ST_IDLE;
              end
            end
            ST_DROP: begin
              if (udp.udpeof) begin
                drop_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign udp.payvalid = payvalid_q;
  assign udp.paysof   = paysof_q;
  assign udp.payeof   = payeof_q;
  assign udp.paydata  = paydata_q;
  assign srcport      = srcport_q;
  assign udplen       = udplen_q;
  assign hdrvalid     = hdrvalid_q;
  assign drop         = drop_q;
  assign lenerr       = lenerr_q;
  assign abort        = abort_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Drives a port-filtering and a non-filtering parser with the same segments and
// compares every output cycle against a segment-level reference model.
module tb_udp_rx_parser;

  typedef struct packed {
    logic        payvalid, paysof, payeof;
    logic [15:0] paydata, srcport, udplen;
    logic        hdrvalid, drop, lenerr, abort;
  } obs_t;

  localparam int MIN_LEN = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] lport;
  logic [15:0] src0, len0, src1, len1;
  logic        hv0, dr0, le0, ab0, hv1, dr1, le1, ab1;

  udp_rx_parser_if u0 ();
  udp_rx_parser_if u1 ();

  assign u1.udpvalidin = u0.udpvalidin;
  assign u1.udpsof     = u0.udpsof;
  assign u1.udpeof     = u0.udpeof;
  assign u1.udpdatain  = u0.udpdatain;

  udp_rx_parser #(.PORT_FILTER(1'b1), .MIN_LEN(16'd8)) dut_f (
    .clock(clock), .reset(reset), .udp(u0), .localport(lport),
    .srcport(src0), .udplen(len0), .hdrvalid(hv0), .drop(dr0), .lenerr(le0), .abort(ab0)
  );

  udp_rx_parser #(.PORT_FILTER(1'b0), .MIN_LEN(16'd8)) dut_a (
    .clock(clock), .reset(reset), .udp(u1), .localport(lport),
    .srcport(src1), .udplen(len1), .hdrvalid(hv1), .drop(dr1), .lenerr(le1), .abort(ab1)
  );

  always #5 clock = ~clock;

  int          n_chk = 0;
  int          n_pass = 0;
  obs_t        obs_q[2][$];
  obs_t        exp_q[2][$];
  logic [15:0] seg[$];
  logic [15:0] m_src[2];
  logic [15:0] m_len[2];
  bit          m_pend[2];

  function automatic obs_t grab(input int k);
    if (k == 0) return {u0.payvalid, u0.paysof, u0.payeof, u0.paydata, src0, len0, hv0, dr0, le0, ab0};
    return {u1.payvalid, u1.paysof, u1.payeof, u1.paydata, src1, len1, hv1, dr1, le1, ab1};
  endfunction

  task automatic step(input logic v, input logic s, input logic e, input logic [15:0] d);
    @(negedge clock);
    u0.udpvalidin = v; u0.udpsof = s; u0.udpeof = e; u0.udpdatain = d;
    @(posedge clock);
    #1;
    obs_q[0].push_back(grab(0));
    obs_q[1].push_back(grab(1));
  endtask

  // Reference: a segment is accepted when all four header words arrive, the
  // port passes the filter and L >= MIN_LEN; everything else follows from that.
  task automatic run_seg(input bit eof_last, input int gap_pct);
    int   n, ex;
    bit   acc[2];
    bit   is_eof;
    obs_t e;
    n  = seg.size();
    ex = (n > 2 && int'(seg[2]) >= 8) ? (int'(seg[2]) - 8 + 1) / 2 : 0;
    for (int k = 0; k < 2; k++)
      acc[k] = (n >= 4) && (k == 1 || seg[1] == lport) && (int'(seg[2]) >= MIN_LEN);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(99) < gap_pct) begin
        for (int k = 0; k < 2; k++) begin
          e = '0; e.srcport = m_src[k]; e.udplen = m_len[k];
          exp_q[k].push_back(e);
        end
        step(1'b0, 1'b0, 1'b0, 16'($urandom));
      end
      is_eof = (i == n - 1) && eof_last;
      for (int k = 0; k < 2; k++) begin
        e = '0;
        if (i == 0) e.abort = m_pend[k];
        if (acc[k] && i == 3) begin
          m_src[k] = seg[0]; m_len[k] = seg[2];
          e.hdrvalid = 1'b1;
          e.lenerr   = is_eof && ex != 0;
        end
        if (acc[k] && i >= 4) begin
          e.payvalid = 1'b1; e.paydata = seg[i]; e.paysof = (i == 4);
          e.payeof   = is_eof;
          e.lenerr   = is_eof && (n - 4 != ex);
        end
        if (!acc[k] && is_eof) e.drop = 1'b1;
        e.srcport = m_src[k]; e.udplen = m_len[k];
        exp_q[k].push_back(e);
      end
      step(1'b1, i == 0, is_eof, seg[i]);
    end
    for (int k = 0; k < 2; k++) m_pend[k] = acc[k] && ex > 0 && !eof_last;
  endtask

  task automatic run_nosof(input int cnt);
    obs_t e;
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < 2; k++) begin
        e = '0; e.srcport = m_src[k]; e.udplen = m_len[k];
        exp_q[k].push_back(e);
      end
      step(1'b1, 1'b0, 1'($urandom_range(1)), 16'($urandom));
    end
  endtask

  task automatic test_reset();
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      o = grab(k);
      n_chk++;
      if (o !== '0) $display("FAIL reset pf%0d got %h want 0", 1 - k, o); else n_pass++;
    end
  endtask

  task automatic test_basic();
    seg = {16'h1234, 16'h0050, 16'h000E, 16'h0000, 16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_seg(1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 2; k++) begin
      exp_q[k].push_back({3'b0, 16'h0, 16'h1234, 16'h000E, 4'b0});
      for (int i = 0; i < exp_q[k].size(); i++) begin
        n_chk++;
        if (obs_q[k][i] !== exp_q[k][i]) $display("FAIL basic pf%0d c%0d got %h want %h", 1 - k, i, obs_q[k][i], exp_q[k][i]);
        else n_pass++;
      end
      obs_q[k].delete(); exp_q[k].delete();
    end
  endtask

  task automatic test_port_mismatch();
    lport = 16'h0051;
    seg = {16'h1234, 16'h0050, 16'h000E, 16'h0000, 16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_seg(1'b1, 0);
    lport = 16'h0050;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < exp_q[k].size(); i++) begin
        n_chk++;
        if (obs_q[k][i] !== exp_q[k][i]) $display("FAIL port pf%0d c%0d got %h want %h", 1 - k, i, obs_q[k][i], exp_q[k][i]);
        else n_pass++;
      end
      obs_q[k].delete(); exp_q[k].delete();
    end
  endtask

  task automatic test_len_error();
    seg = {16'h4321, 16'h0050, 16'h0010, 16'hFFFF, 16'h0101, 16'h0202, 16'h0303};
    run_seg(1'b1, 0);
    // Odd length: last word keeps its full 16 bits on the way out.
    seg = {16'h0A0B, 16'h0050, 16'h000D, 16'h1111, 16'h1234, 16'h5678, 16'h9AFF};
    run_seg(1'b1, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < exp_q[k].size(); i++) begin
        n_chk++;
        if (obs_q[k][i] !== exp_q[k][i]) $display("FAIL lenerr pf%0d c%0d got %h want %h", 1 - k, i, obs_q[k][i], exp_q[k][i]);
        else n_pass++;
      end
      obs_q[k].delete(); exp_q[k].delete();
    end
  endtask

  task automatic test_runt_empty();
    seg = {16'h1111, 16'h0050, 16'h000E};
    run_seg(1'b1, 0);
    seg = {16'h2222, 16'h0050, 16'h0008, 16'h0000};
    run_seg(1'b1, 0);
    seg = {16'h3333};
    run_seg(1'b1, 0);
    seg = {16'h4444, 16'h0050, 16'h0005, 16'h0000, 16'h5555};
    run_seg(1'b1, 0);
    seg = {16'h6666, 16'h0050, 16'h0012, 16'h0000};
    run_seg(1'b1, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < exp_q[k].size(); i++) begin
        n_chk++;
        if (obs_q[k][i] !== exp_q[k][i]) $display("FAIL runt pf%0d c%0d got %h want %h", 1 - k, i, obs_q[k][i], exp_q[k][i]);
        else n_pass++;
      end
      obs_q[k].delete(); exp_q[k].delete();
    end
  endtask

  task automatic test_gaps_restart();
    seg = {16'hABCD, 16'h0050, 16'h0010, 16'h0000, 16'h1001, 16'h2002, 16'h3003, 16'h4004};
    run_seg(1'b1, 60);
    seg = {16'hBEEF, 16'h0050, 16'h0014, 16'h0000, 16'h5005, 16'h6006};
    run_seg(1'b0, 60);
    seg = {16'hCAFE, 16'h0050, 16'h000C, 16'h0000, 16'h7007, 16'h8008};
    run_seg(1'b1, 40);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < exp_q[k].size(); i++) begin
        n_chk++;
        if (obs_q[k][i] !== exp_q[k][i]) $display("FAIL gaps pf%0d c%0d got %h want %h", 1 - k, i, obs_q[k][i], exp_q[k][i]);
        else n_pass++;
      end
      obs_q[k].delete(); exp_q[k].delete();
    end
  endtask

  task automatic test_random();
    int n, ex;
    bit eof;
    logic [15:0] l;
    lport = 16'($urandom);
    for (int s = 0; s < 60; s++) begin
      n   = $urandom_range(10, 1);
      eof = $urandom_range(99) < 85;
      if (n > 4) begin
        ex = n - 4 + $urandom_range(2) - 1;
        if (ex < 1) ex = 1;
      end else ex = $urandom_range(3);
      l = (ex == 0) ? 16'd8 : 16'(2 * ex + 7 + $urandom_range(1));
      if ($urandom_range(9) == 0) l = 16'($urandom_range(7));
      seg = {16'($urandom), ($urandom_range(99) < 70) ? lport : 16'($urandom), l, 16'($urandom)};
      while (seg.size() < n) seg.push_back(16'($urandom));
      while (seg.size() > n) void'(seg.pop_back());
      run_seg(eof, 25);
    end
    lport = 16'h0050;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < exp_q[k].size(); i++) begin
        n_chk++;
        if (obs_q[k][i] !== exp_q[k][i]) $display("FAIL random pf%0d c%0d got %h want %h", 1 - k, i, obs_q[k][i], exp_q[k][i]);
        else n_pass++;
      end
      obs_q[k].delete(); exp_q[k].delete();
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    seg = {16'h7777, 16'h0050, 16'h0010, 16'h0000, 16'hD00D, 16'hE00E};
    run_seg(1'b0, 0);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      o = grab(k);
      n_chk++;
      if (o !== '0) $display("FAIL async_reset pf%0d got %h want 0", 1 - k, o); else n_pass++;
      m_src[k] = '0; m_len[k] = '0; m_pend[k] = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_nosof(5);
    seg = {16'h8888, 16'h0050, 16'h000E, 16'h0000, 16'hF00F, 16'hF11F, 16'hF22F};
    run_seg(1'b1, 20);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < exp_q[k].size(); i++) begin
        n_chk++;
        if (obs_q[k][i] !== exp_q[k][i]) $display("FAIL post_reset pf%0d c%0d got %h want %h", 1 - k, i, obs_q[k][i], exp_q[k][i]);
        else n_pass++;
      end
      obs_q[k].delete(); exp_q[k].delete();
    end
  endtask

  initial begin
    u0.udpvalidin = 1'b0; u0.udpsof = 1'b0; u0.udpeof = 1'b0; u0.udpdatain = '0;
    lport = 16'h0050;
    for (int k = 0; k < 2; k++) begin m_src[k] = '0; m_len[k] = '0; m_pend[k] = 1'b0; end
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset = 1'b0;
    test_basic();
    test_port_mismatch();
    test_len_error();
    test_runt_empty();
    test_gaps_restart();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
